// File: rtl/wr_ctrl_pkg.sv
// Shared types and burst-sizing arithmetic for the packet burst write controller.
package wr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_BURST,
    ST_DONE
  } wr_state_t;

  // Burst length: limited by words left, the burst cap and the next cap-aligned boundary.
  function automatic logic [63:0] burst_len(input logic [63:0] remaining,
                                            input logic [63:0] addr_word,
                                            input logic [63:0] max_burst);
    logic [63:0] to_bound;
    logic [63:0] len;
    to_bound = max_burst - (addr_word & (max_burst - 64'd1));
    len      = remaining;
    if (max_burst < len) len = max_burst;
    if (to_bound < len)  len = to_bound;
    return len;
  endfunction

endpackage

// File: rtl/wr_burst_len.sv
// Combinational burst-length calculator: words per burst from remaining count and byte address.
module wr_burst_len
  import wr_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int BURST_W   = 16
) (
  input  logic [ADDR_W-1:0]  remaining,
  input  logic [ADDR_W-1:0]  addr,
  output logic [BURST_W-1:0] len
);

  localparam int ADDR_LSB = $clog2(DATA_W / 8);

  logic [ADDR_W-1:0] addr_word;

  assign addr_word = addr >> ADDR_LSB;
  assign len       = BURST_W'(burst_len(64'(remaining), 64'(addr_word), 64'(MAX_BURST)));

endmodule

// File: rtl/wr_burst_ctrl.sv
// Packet write controller: drains a show-ahead FIFO into memory as aligned Avalon-MM bursts.
module wr_burst_ctrl
  import wr_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int BURST_W   = 16,
  parameter int FILL_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_ctrl,
  input  logic [ADDR_W-1:0]  pkt_begin,
  input  logic [ADDR_W-1:0]  pkt_end,
  input  logic [FILL_W-1:0]  fifo_usedw,
  input  logic [DATA_W-1:0]  fifo_out,
  output logic               fifo_rd,
  output logic               wr_ctrl_rdy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W-1:0]  address,
  output logic [DATA_W-1:0]  writedata,
  output logic               write,
  output logic [BURST_W-1:0] burstcount,
  input  logic               waitrequest
);

  localparam int BYTES    = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(BYTES);
  localparam int CMP_W    = (FILL_W > BURST_W) ? FILL_W : BURST_W;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

  wr_state_t          state, state_nxt;
  logic [ADDR_W-1:0]  addr_q, addr_nxt;
  logic [ADDR_W-1:0]  rem_q, rem_nxt;
  logic [BURST_W-1:0] len_q, len_nxt, len_calc;
  logic [BURST_W-1:0] beat_q, beat_nxt;
  logic               err_q, err_nxt;
  logic               beat_ok, bad_req;

  wr_burst_len #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MAX_BURST(MAX_BURST),
    .BURST_W  (BURST_W)
  ) u_len (
    .remaining(rem_q),
    .addr     (addr_q),
    .len      (len_calc)
  );

  assign bad_req = (pkt_end < pkt_begin) ||
                   ((pkt_begin & ALIGN_MASK) != '0) ||
                   ((pkt_end & ALIGN_MASK) != '0);

  // Write is decoded from state so an asynchronous reset drops it immediately.
  assign write       = (state == ST_BURST);
  assign beat_ok     = write & ~waitrequest;
  assign fifo_rd     = beat_ok;
  assign writedata   = write ? fifo_out : '0;
  assign address     = addr_q;
  assign burstcount  = len_q;
  assign wr_ctrl_rdy = (state == ST_IDLE);
  assign done        = (state == ST_DONE);
  assign err         = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      rem_q  <= '0;
      len_q  <= '0;
      beat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      rem_q  <= rem_nxt;
      len_q  <= len_nxt;
      beat_q <= beat_nxt;
      err_q  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    rem_nxt   = rem_q;
    len_nxt   = len_q;
    beat_nxt  = beat_q;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_ctrl) begin
          if (bad_req) begin
            err_nxt = 1'b1;
          end else begin
            addr_nxt  = pkt_begin;
            rem_nxt   = (pkt_end - pkt_begin) >> ADDR_LSB;
            state_nxt = (pkt_end == pkt_begin) ? ST_DONE : ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        len_nxt   = len_calc;
        beat_nxt  = '0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Only start once the whole burst is already buffered, so beats never stall on data.
        if (CMP_W'(fifo_usedw) >= CMP_W'(len_q)) state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (beat_ok) begin
          if (beat_q == len_q - BURST_W'(1)) begin
            addr_nxt  = addr_q + (ADDR_W'(len_q) << ADDR_LSB);
            rem_nxt   = rem_q - ADDR_W'(len_q);
            state_nxt = (rem_q == ADDR_W'(len_q)) ? ST_DONE : ST_SETUP;
          end else begin
            beat_nxt = beat_q + BURST_W'(1);
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wr_burst_ctrl.sv
// Directed bench for wr_burst_ctrl with a show-ahead FIFO model and an Avalon beat monitor.
module tb_wr_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_ctrl;
  logic [31:0] pkt_begin, pkt_end;
  logic [7:0]  fifo_usedw = '0;
  logic [31:0] fifo_out = '0;
  logic        fifo_rd, wr_ctrl_rdy, done, err, write;
  logic [31:0] address, writedata;
  logic [15:0] burstcount;
  logic        waitrequest = 1'b0;

  wr_burst_ctrl #(
    .DATA_W(32), .ADDR_W(32), .MAX_BURST(16), .BURST_W(16), .FILL_W(8)
  ) dut (
    .clk(clk), .reset(reset), .wr_ctrl(wr_ctrl), .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .fifo_usedw(fifo_usedw), .fifo_out(fifo_out), .fifo_rd(fifo_rd), .wr_ctrl_rdy(wr_ctrl_rdy),
    .done(done), .err(err), .address(address), .writedata(writedata), .write(write),
    .burstcount(burstcount), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] q[$];
  int cap = 255;
  int pops = 0;
  int fifo_sz;
  bit wr_rand = 1'b0;

  logic [31:0] beat_data[$];
  logic [31:0] b_addr[$];
  logic [15:0] b_len[$];
  int stab_bad = 0, early_bad = 0, done_cnt = 0, err_cnt = 0, write_cyc = 0;
  logic prev_write = 1'b0;

  // Show-ahead FIFO: pops on an accepted beat, outputs refresh on the clock edge.
  always @(posedge clk) begin
    if (fifo_rd && q.size() > 0) begin
      q.delete(0);
      pops++;
    end
    fifo_sz = q.size();
    fifo_usedw <= 8'((fifo_sz < cap) ? fifo_sz : cap);
    fifo_out   <= (fifo_sz > 0) ? q[0] : 32'h0;
  end

  // Beat/burst monitor, sampled mid-cycle.
  always @(negedge clk) begin
    waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    if (write) begin
      write_cyc++;
      if (!prev_write) begin
        b_addr.push_back(address);
        b_len.push_back(burstcount);
        if (32'(fifo_usedw) < 32'(burstcount)) early_bad++;
      end else if (address != b_addr[$] || burstcount != b_len[$]) begin
        stab_bad++;
      end
      if (!waitrequest) beat_data.push_back(writedata);
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    prev_write = write;
  end

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) q.push_back(32'(base + i));
  endtask

  task automatic strobe(input logic [31:0] b, input logic [31:0] e);
    @(negedge clk);
    wr_ctrl = 1'b1; pkt_begin = b; pkt_end = e;
    @(negedge clk);
    wr_ctrl = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; wr_ctrl = 1'b0; pkt_begin = '0; pkt_end = '0;
    load(32'hDEAD, 1);
    repeat (3) @(negedge clk);
    #2;
    total++;
    if (write !== 1'b0 || fifo_rd !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: got write=%b rd=%b done=%b err=%b want all 0", write, fifo_rd, done, err);
    end
    total++;
    if (wr_ctrl_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %b want 1", wr_ctrl_rdy); end
    total++;
    if (address !== 32'h0 || writedata !== 32'h0 || burstcount !== 16'h0) begin
      bad++; $display("FAIL reset_bus: got addr=%h data=%h bc=%0d want 0/0/0", address, writedata, burstcount);
    end
    reset = 1'b1;
    q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    int bd0, ba0, p0, d0;
    bit ok;
    bd0 = beat_data.size(); ba0 = b_addr.size(); p0 = pops; d0 = done_cnt;
    load(10, 8);
    strobe(32'h0, 32'd32);
    #2;
    total++;
    if (wr_ctrl_rdy !== 1'b0) begin bad++; $display("FAIL single_busy: got rdy=%b want 0", wr_ctrl_rdy); end
    @(negedge clk); #2;
    total++;
    if (write !== 1'b0) begin bad++; $display("FAIL single_latency_early: got write=%b want 0", write); end
    @(negedge clk); #2;
    total++;
    if (write !== 1'b1 || address !== 32'h0 || burstcount !== 16'd8 || writedata !== 32'd10) begin
      bad++; $display("FAIL single_first_beat: got w=%b a=%h bc=%0d d=%0d want 1/0/8/10", write, address, burstcount, writedata);
    end
    wait_done(d0 + 1, 100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_done_timeout: got no done want done"); end
    @(negedge clk); #2;
    total++;
    if (wr_ctrl_rdy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL single_rdy_after_done: got rdy=%b done=%b want 1/0", wr_ctrl_rdy, done);
    end
    total++;
    if (b_addr.size() - ba0 != 1 || b_addr[ba0] !== 32'h0 || b_len[ba0] !== 16'd8) begin
      bad++; $display("FAIL single_burst: got n=%0d want 1 burst 8@0", b_addr.size() - ba0);
    end
    total++;
    if (beat_data.size() - bd0 != 8) begin
      bad++; $display("FAIL single_beats: got %0d want 8", beat_data.size() - bd0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (beat_data[bd0 + i] !== 32'(10 + i)) begin
          bad++; $display("FAIL single_data[%0d]: got %0d want %0d", i, beat_data[bd0 + i], 10 + i);
        end
      end
    end
    total++;
    if (pops - p0 != 8 || q.size() != 0) begin
      bad++; $display("FAIL single_pops: got pops=%0d left=%0d want 8/0", pops - p0, q.size());
    end
  endtask

  task automatic test_split;
    logic [31:0] ea[3];
    logic [15:0] el[3];
    int bd0, ba0, p0, d0, s0;
    bit ok;
    ea = '{32'h0, 32'h40, 32'h80}; el = '{16'd16, 16'd16, 16'd8};
    bd0 = beat_data.size(); ba0 = b_addr.size(); p0 = pops; d0 = done_cnt; s0 = stab_bad;
    load(100, 40);
    strobe(32'h0, 32'hA0);
    wait_done(d0 + 1, 300, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL split_done_timeout: got no done want done"); end
    total++;
    if (b_addr.size() - ba0 != 3) begin
      bad++; $display("FAIL split_nbursts: got %0d want 3", b_addr.size() - ba0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (b_addr[ba0 + i] !== ea[i] || b_len[ba0 + i] !== el[i]) begin
          bad++; $display("FAIL split_burst[%0d]: got %0d@%h want %0d@%h", i, b_len[ba0 + i], b_addr[ba0 + i], el[i], ea[i]);
        end
      end
    end
    total++;
    if (stab_bad != s0) begin bad++; $display("FAIL split_stable: got %0d changes want 0", stab_bad - s0); end
    total++;
    if (beat_data.size() - bd0 != 40) begin
      bad++; $display("FAIL split_beats: got %0d want 40", beat_data.size() - bd0);
    end else begin
      for (int i = 0; i < 40; i++) begin
        total++;
        if (beat_data[bd0 + i] !== 32'(100 + i)) begin
          bad++; $display("FAIL split_data[%0d]: got %0d want %0d", i, beat_data[bd0 + i], 100 + i);
        end
      end
    end
    total++;
    if (pops - p0 != 40) begin bad++; $display("FAIL split_pops: got %0d want 40", pops - p0); end
  endtask

  task automatic test_boundary;
    logic [31:0] ea[3];
    logic [15:0] el[3];
    int bd0, ba0, d0;
    bit ok;
    ea = '{32'h38, 32'h40, 32'h80}; el = '{16'd2, 16'd16, 16'd2};
    bd0 = beat_data.size(); ba0 = b_addr.size(); d0 = done_cnt;
    load(200, 20);
    strobe(32'h38, 32'h88);
    wait_done(d0 + 1, 200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bound_done_timeout: got no done want done"); end
    total++;
    if (b_addr.size() - ba0 != 3) begin
      bad++; $display("FAIL bound_nbursts: got %0d want 3", b_addr.size() - ba0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (b_addr[ba0 + i] !== ea[i] || b_len[ba0 + i] !== el[i]) begin
          bad++; $display("FAIL bound_burst[%0d]: got %0d@%h want %0d@%h", i, b_len[ba0 + i], b_addr[ba0 + i], el[i], ea[i]);
        end
      end
    end
    total++;
    if (beat_data.size() - bd0 != 20 || beat_data[bd0 + 19] !== 32'd219) begin
      bad++; $display("FAIL bound_beats: got %0d beats want 20 ending at 219", beat_data.size() - bd0);
    end
  endtask

  task automatic test_backpressure;
    int bd0, ba0, p0, d0, e0;
    bit ok;
    bd0 = beat_data.size(); ba0 = b_addr.size(); p0 = pops; d0 = done_cnt; e0 = early_bad;
    cap = 0;
    wr_rand = 1'b1;
    load(300, 24);
    strobe(32'h100, 32'h160);
    for (int i = 1; i <= 24; i++) begin
      cap = i;
      repeat (3) @(negedge clk);
    end
    wait_done(d0 + 1, 400, ok);
    wr_rand = 1'b0;
    cap = 255;
    total++;
    if (!ok) begin bad++; $display("FAIL bp_done_timeout: got no done want done"); end
    total++;
    if (early_bad != e0) begin bad++; $display("FAIL bp_early_write: got %0d early bursts want 0", early_bad - e0); end
    total++;
    if (b_addr.size() - ba0 != 2 || b_addr[ba0] !== 32'h100 || b_len[ba0] !== 16'd16 ||
        b_addr[ba0 + 1] !== 32'h140 || b_len[ba0 + 1] !== 16'd8) begin
      bad++; $display("FAIL bp_bursts: got n=%0d want 16@100 8@140", b_addr.size() - ba0);
    end
    total++;
    if (beat_data.size() - bd0 != 24) begin
      bad++; $display("FAIL bp_beats: got %0d want 24", beat_data.size() - bd0);
    end else begin
      for (int i = 0; i < 24; i++) begin
        total++;
        if (beat_data[bd0 + i] !== 32'(300 + i)) begin
          bad++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, beat_data[bd0 + i], 300 + i);
        end
      end
    end
    total++;
    if (pops - p0 != 24) begin bad++; $display("FAIL bp_pops: got %0d want 24", pops - p0); end
  endtask

  task automatic test_empty_reject;
    int w0, d0, r0;
    w0 = write_cyc; d0 = done_cnt; r0 = err_cnt;
    strobe(32'h40, 32'h40);
    #2;
    total++;
    if (done !== 1'b1 || write !== 1'b0) begin bad++; $display("FAIL empty_done: got done=%b write=%b want 1/0", done, write); end
    @(negedge clk); #2;
    total++;
    if (done !== 1'b0 || wr_ctrl_rdy !== 1'b1) begin bad++; $display("FAIL empty_end: got done=%b rdy=%b want 0/1", done, wr_ctrl_rdy); end
    strobe(32'h80, 32'h40);
    #2;
    total++;
    if (err !== 1'b1 || wr_ctrl_rdy !== 1'b1) begin bad++; $display("FAIL rev_err: got err=%b rdy=%b want 1/1", err, wr_ctrl_rdy); end
    @(negedge clk); #2;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL rev_err_pulse: got err=%b want 0", err); end
    strobe(32'h2, 32'h42);
    #2;
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL align_err: got err=%b want 1", err); end
    repeat (3) @(negedge clk);
    #2;
    total++;
    if (write_cyc != w0 || done_cnt - d0 != 1 || err_cnt - r0 != 2) begin
      bad++; $display("FAIL reject_counts: got writes=%0d dones=%0d errs=%0d want 0/1/2", write_cyc - w0, done_cnt - d0, err_cnt - r0);
    end
  endtask

  task automatic test_ignore;
    int ba0, w0, d0;
    bit ok;
    ba0 = b_addr.size(); w0 = write_cyc; d0 = done_cnt;
    load(600, 8);
    strobe(32'h200, 32'h220);
    repeat (4) @(negedge clk);
    wr_ctrl = 1'b1; pkt_begin = 32'h400; pkt_end = 32'h440;
    repeat (2) @(negedge clk);
    wr_ctrl = 1'b0;
    wait_done(d0 + 1, 100, ok);
    repeat (10) @(negedge clk);
    #2;
    total++;
    if (!ok) begin bad++; $display("FAIL ignore_done_timeout: got no done want done"); end
    total++;
    if (write_cyc - w0 != 8 || b_addr.size() - ba0 != 1 || b_addr[ba0] !== 32'h200 || done_cnt - d0 != 1) begin
      bad++; $display("FAIL ignore_busy_strobe: got writes=%0d bursts=%0d dones=%0d want 8/1/1", write_cyc - w0, b_addr.size() - ba0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    int bd0, d0;
    bit ok;
    bd0 = beat_data.size(); d0 = done_cnt;
    load(400, 8);
    strobe(32'h300, 32'h320);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #2;
      if (beat_data.size() - bd0 >= 3) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL rst_beat3_timeout: got %0d beats want 3", beat_data.size() - bd0); end
    reset = 1'b0;
    #1;
    total++;
    if (write !== 1'b0 || wr_ctrl_rdy !== 1'b1 || fifo_rd !== 1'b0) begin
      bad++; $display("FAIL rst_async: got write=%b rdy=%b rd=%b want 0/1/0", write, wr_ctrl_rdy, fifo_rd);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    total++;
    if (q.size() != 6 || done_cnt != d0) begin
      bad++; $display("FAIL rst_leftover: got left=%0d dones=%0d want 6/0", q.size(), done_cnt - d0);
    end
    q.delete();
    repeat (2) @(negedge clk);
    bd0 = beat_data.size();
    load(500, 8);
    strobe(32'h300, 32'h320);
    wait_done(d0 + 1, 100, ok);
    total++;
    if (!ok || beat_data.size() - bd0 != 8 || beat_data[bd0] !== 32'd500 || beat_data[bd0 + 7] !== 32'd507) begin
      bad++; $display("FAIL rst_recover: got ok=%b beats=%0d want 1/8 data 500..507", ok, beat_data.size() - bd0);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_split;
    test_boundary;
    test_backpressure;
    test_empty_reject;
    test_ignore;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
